// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two per-source result FIFOs with same-cycle bypass,
// round-robin grant, and a registered single-broadcast CDB output.

module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 36
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         clr,
  input  logic         fi,
  input  logic [W-1:0] din,
  input  logic         gnt,
  output logic         req,
  output logic [W-1:0] cand,
  output logic         full,
  output logic         ovf
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           head_q, head_d, tail_q, tail_d;
  logic [PW:0]             cnt_q, cnt_d;
  logic                    empty, pop, push, wr;

  always_comb begin
    empty  = (cnt_q == '0);
    full   = (cnt_q == (PW+1)'(DEPTH));
    req    = !empty || fi;
    cand   = empty ? din : mem_q[head_q];
    pop    = gnt && !empty;
    // A granted arrival with an empty FIFO goes straight to the bus.
    push   = fi && !(gnt && empty);
    ovf    = push && full && !pop;
    wr     = push && !ovf;
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    if (wr) begin
      mem_d[tail_q] = din;
      tail_d        = tail_q + 1'b1;
    end
    if (pop) head_d = head_q + 1'b1;
    cnt_d = cnt_q + (PW+1)'(wr) - (PW+1)'(pop);
    if (clr) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      mem_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (rdy_in) begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int ROB_SIZE_BIT = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    rob_clear,
  input  logic                    alu_fi,
  input  logic [31:0]             alu_value,
  input  logic [ROB_SIZE_BIT-1:0] alu_rob_id,
  input  logic                    lsb_fi,
  input  logic [31:0]             lsb_value,
  input  logic [ROB_SIZE_BIT-1:0] lsb_rob_id,
  output logic                    alu_full,
  output logic                    lsb_full,
  output logic                    cdb_fi,
  output logic [31:0]             cdb_value,
  output logic [ROB_SIZE_BIT-1:0] cdb_rob_id,
  output logic                    cdb_src,
  output logic                    overflow_err
);
  localparam int NSRC = 2;
  localparam int W    = 32 + ROB_SIZE_BIT;

  typedef struct packed {
    logic [31:0]             value;
    logic [ROB_SIZE_BIT-1:0] rob_id;
  } cdb_ent_t;

  cdb_ent_t [NSRC-1:0] din, cand;
  logic     [NSRC-1:0] fi, req, gnt, full, ovf;
  logic                any, gsrc;

  cdb_ent_t ent_q, ent_d;
  logic     cdb_fi_q, cdb_fi_d, src_q, src_d, rr_last_q, rr_last_d, ovf_q, ovf_d;

  assign fi     = {lsb_fi, alu_fi};
  assign din[0] = {alu_value, alu_rob_id};
  assign din[1] = {lsb_value, lsb_rob_id};

  generate
    for (genvar s = 0; s < NSRC; s++) begin : g_src
      cdb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clr    (rob_clear),
        .fi     (fi[s]),
        .din    (din[s]),
        .gnt    (gnt[s]),
        .req    (req[s]),
        .cand   (cand[s]),
        .full   (full[s]),
        .ovf    (ovf[s])
      );
    end
  endgenerate

  always_comb begin
    any       = |req;
    gsrc      = (&req) ? ~rr_last_q : req[1];
    gnt       = any ? (gsrc ? 2'b10 : 2'b01) : 2'b00;
    cdb_fi_d  = any;
    ent_d     = any ? cand[gsrc] : ent_q;
    src_d     = any ? gsrc : src_q;
    rr_last_d = any ? gsrc : rr_last_q;
    ovf_d     = ovf_q | (|ovf);
    // Flush drops everything in flight, including this cycle's arrivals.
    if (rob_clear) begin
      cdb_fi_d  = 1'b0;
      ent_d     = ent_q;
      src_d     = src_q;
      rr_last_d = 1'b1;
      ovf_d     = ovf_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cdb_fi_q  <= 1'b0;
      ent_q     <= '0;
      src_q     <= 1'b0;
      rr_last_q <= 1'b1;
      ovf_q     <= 1'b0;
    end else if (rdy_in) begin
      cdb_fi_q  <= cdb_fi_d;
      ent_q     <= ent_d;
      src_q     <= src_d;
      rr_last_q <= rr_last_d;
      ovf_q     <= ovf_d;
    end
  end

  assign alu_full     = full[0];
  assign lsb_full     = full[1];
  assign cdb_fi       = cdb_fi_q;
  assign cdb_value    = ent_q.value;
  assign cdb_rob_id   = ent_q.rob_id;
  assign cdb_src      = src_q;
  assign overflow_err = ovf_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: per-source scoreboards check data and FIFO order,
// directed per-cycle checks cover arbitration, timing, flush, overflow and stall.

module tb_cdb_arbiter;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_clear;
  logic        alu_fi, lsb_fi;
  logic [31:0] alu_value, lsb_value;
  logic [3:0]  alu_rob_id, lsb_rob_id;
  logic        alu_full, lsb_full, cdb_fi, cdb_src, overflow_err;
  logic [31:0] cdb_value;
  logic [3:0]  cdb_rob_id;

  int n_chk = 0;
  int n_err = 0;
  logic [35:0] exp_a[$];
  logic [35:0] exp_l[$];
  logic        upd = 1'b0;

  cdb_arbiter #(.DEPTH(2), .ROB_SIZE_BIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .alu_fi(alu_fi), .alu_value(alu_value), .alu_rob_id(alu_rob_id),
    .lsb_fi(lsb_fi), .lsb_value(lsb_value), .lsb_rob_id(lsb_rob_id),
    .alu_full(alu_full), .lsb_full(lsb_full), .cdb_fi(cdb_fi),
    .cdb_value(cdb_value), .cdb_rob_id(cdb_rob_id), .cdb_src(cdb_src),
    .overflow_err(overflow_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // A new broadcast exists only after an edge that was not reset or stalled.
  always @(posedge clk_in) upd <= rst_in && rdy_in;

  always @(negedge clk_in) begin
    if (upd && cdb_fi) begin
      if (cdb_src == 1'b0) begin
        if (exp_a.size() == 0) chk("sb_unexp_alu", 64'(cdb_fi), 64'd0);
        else chk("sb_alu", {cdb_value, cdb_rob_id}, exp_a.pop_front());
      end else begin
        if (exp_l.size() == 0) chk("sb_unexp_lsb", 64'(cdb_fi), 64'd0);
        else chk("sb_lsb", {cdb_value, cdb_rob_id}, exp_l.pop_front());
      end
    end
  end

  task automatic drive_both(input int k);
    alu_fi = 1'b1; alu_value = 32'hA000_0000 + k; alu_rob_id = 4'd1;
    lsb_fi = 1'b1; lsb_value = 32'hB000_0000 + k; lsb_rob_id = 4'd2;
    exp_a.push_back({alu_value, alu_rob_id});
    exp_l.push_back({lsb_value, lsb_rob_id});
  endtask

  initial begin
    logic [3:0] t3_src;
    logic [3:0] t3_af;
    logic [3:0] t3_lf;
    t3_src = 4'b1010; t3_af = 4'b1000; t3_lf = 4'b0100;
    rst_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0;
    alu_fi = 1'b0; alu_value = '0; alu_rob_id = '0;
    lsb_fi = 1'b0; lsb_value = '0; lsb_rob_id = '0;
    tick(); tick();
    chk("rst_fi", 64'(cdb_fi), 0);
    chk("rst_value", 64'(cdb_value), 0);
    chk("rst_alu_full", 64'(alu_full), 0);
    chk("rst_lsb_full", 64'(lsb_full), 0);
    chk("rst_ovf", 64'(overflow_err), 0);
    rst_in = 1'b1;

    // single ALU result, 1-cycle latency
    alu_fi = 1'b1; alu_value = 32'h1234_5678; alu_rob_id = 4'd3;
    exp_a.push_back({alu_value, alu_rob_id});
    tick();
    alu_fi = 1'b0;
    chk("single_fi", 64'(cdb_fi), 1);
    chk("single_src", 64'(cdb_src), 0);
    chk("single_id", 64'(cdb_rob_id), 3);
    tick();
    chk("single_idle", 64'(cdb_fi), 0);

    rob_clear = 1'b1; tick(); rob_clear = 1'b0;

    // both producers, respecting full flags
    for (int k = 0; k < 4; k++) begin
      alu_fi = !alu_full; alu_value = 32'hA000_0000 + k; alu_rob_id = 4'd1;
      lsb_fi = !lsb_full; lsb_value = 32'hB000_0000 + k; lsb_rob_id = 4'd2;
      if (alu_fi) exp_a.push_back({alu_value, alu_rob_id});
      if (lsb_fi) exp_l.push_back({lsb_value, lsb_rob_id});
      tick();
      chk("alt_src", 64'(cdb_src), 64'(t3_src[k]));
      chk("alt_id", 64'(cdb_rob_id), t3_src[k] ? 64'd2 : 64'd1);
      chk("alt_alu_full", 64'(alu_full), 64'(t3_af[k]));
      chk("alt_lsb_full", 64'(lsb_full), 64'(t3_lf[k]));
    end
    alu_fi = 1'b0; lsb_fi = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("drain_fi", 64'(cdb_fi), 1);
      chk("drain_src", 64'(cdb_src), 64'(k % 2));
    end
    tick();
    chk("drain_idle", 64'(cdb_fi), 0);
    chk("alt_ovf", 64'(overflow_err), 0);

    // LSB burst, ALU idle
    for (int k = 4; k <= 6; k++) begin
      lsb_fi = 1'b1; lsb_value = 32'hC000_0000 + k; lsb_rob_id = 4'(k);
      exp_l.push_back({lsb_value, lsb_rob_id});
      tick();
      chk("burst_id", 64'(cdb_rob_id), 64'(k));
      chk("burst_src", 64'(cdb_src), 1);
    end
    lsb_fi = 1'b0;
    tick();
    chk("burst_idle", 64'(cdb_fi), 0);

    // fill both FIFOs to two entries, then flush
    for (int k = 0; k < 4; k++) begin
      drive_both(16 + k);
      tick();
      chk("fill_src", 64'(cdb_src), 64'(k % 2));
    end
    chk("fill_alu_full", 64'(alu_full), 1);
    chk("fill_lsb_full", 64'(lsb_full), 1);
    lsb_fi = 1'b0;
    alu_fi = 1'b1; alu_value = 32'hDEAD_0009; alu_rob_id = 4'd9;
    rob_clear = 1'b1;
    tick();
    rob_clear = 1'b0; alu_fi = 1'b0;
    exp_a.delete(); exp_l.delete();
    chk("clr_fi", 64'(cdb_fi), 0);
    chk("clr_alu_full", 64'(alu_full), 0);
    chk("clr_lsb_full", 64'(lsb_full), 0);
    alu_fi = 1'b1; alu_value = 32'h0000_0777; alu_rob_id = 4'd7;
    exp_a.push_back({alu_value, alu_rob_id});
    tick();
    alu_fi = 1'b0;
    chk("post_clr_fi", 64'(cdb_fi), 1);
    chk("post_clr_id", 64'(cdb_rob_id), 7);
    tick();
    chk("post_clr_idle", 64'(cdb_fi), 0);

    // overflow: LSB full, ALU wins, LSB pushes anyway
    rob_clear = 1'b1; tick(); rob_clear = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_both(32 + k);
      tick();
    end
    chk("ovf_pre", 64'(overflow_err), 0);
    alu_fi = 1'b0;
    lsb_fi = 1'b1; lsb_value = 32'hBAD0_BAD0; lsb_rob_id = 4'd13;
    tick();
    lsb_fi = 1'b0;
    chk("ovf_src", 64'(cdb_src), 0);
    chk("ovf_set", 64'(overflow_err), 1);
    rob_clear = 1'b1; tick(); rob_clear = 1'b0;
    exp_a.delete(); exp_l.delete();
    chk("ovf_sticky", 64'(overflow_err), 1);

    // stall with a queued LSB entry
    alu_fi = 1'b1; alu_value = 32'h0000_0AAA; alu_rob_id = 4'd10;
    lsb_fi = 1'b1; lsb_value = 32'h0000_0BBB; lsb_rob_id = 4'd11;
    exp_a.push_back({alu_value, alu_rob_id});
    exp_l.push_back({lsb_value, lsb_rob_id});
    tick();
    chk("hold_pre_id", 64'(cdb_rob_id), 10);
    lsb_fi = 1'b0;
    alu_value = 32'h0000_0CCC; alu_rob_id = 4'd12;
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_fi", 64'(cdb_fi), 1);
      chk("hold_id", 64'(cdb_rob_id), 10);
      chk("hold_value", 64'(cdb_value), 64'h0AAA);
      chk("hold_lsb_full", 64'(lsb_full), 0);
    end
    rdy_in = 1'b1; alu_fi = 1'b0;
    tick();
    chk("release_src", 64'(cdb_src), 1);
    chk("release_id", 64'(cdb_rob_id), 11);
    tick();
    chk("release_idle", 64'(cdb_fi), 0);

    tick();
    chk("sb_drained", 64'(exp_a.size() + exp_l.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares a single common data bus (CDB) between the two result producers, the ALU (fed by the reservation station) and the load/store buffer, so downstream consumers (RS, LSB, ROB) snoop one broadcast per cycle. Each producer gets a small FIFO. A round-robin grant selects one result per cycle, and the result is driven on a registered CDB output. Backpressure flags tell the RS issue logic and the LSB when their queue cannot accept a result.

## Interface
Parameters:
- DEPTH, 2: entries per source FIFO (≥2, power of two).
- ROB_SIZE_BIT, 4: width of ROB ids.

Ports:
- clk_in  in  1  system clock; the only clock.
- rst_in  in  1  reset, synchronous, active-low.
- rdy_in  in  1  global ready; low = hold all state, ignore inputs.
- rob_clear  in  1  misprediction flush; discards all pending results.
- alu_fi  in  1  ALU result valid this cycle.
- alu_value  in  32  ALU result.
- alu_rob_id  in  ROB_SIZE_BIT  ALU result ROB id.
- lsb_fi  in  1  LSB result valid this cycle.
- lsb_value  in  32  LSB result.
- lsb_rob_id  in  ROB_SIZE_BIT  LSB result ROB id.
- alu_full  out  1  ALU FIFO holds DEPTH entries; RS must not issue.
- lsb_full  out  1  LSB FIFO holds DEPTH entries; LSB must not complete.
- cdb_fi  out  1  broadcast valid (registered).
- cdb_value  out  32  broadcast value (registered).
- cdb_rob_id  out  ROB_SIZE_BIT  broadcast ROB id (registered).
- cdb_src  out  1  0 = ALU, 1 = LSB (registered).
- overflow_err  out  1  sticky; a push arrived while the FIFO was full and not popping.

## Operation
- Per source X ∈ {ALU, LSB}: circular FIFO with head/tail pointers (log2 DEPTH bits, wrap-around) and count (0..DEPTH).
- Request: req_X = (count_X != 0) || X_fi.
- Candidate for X:
  - FIFO head if count_X != 0.
  - Otherwise the incoming X_fi data (bypass, no FIFO write).
- Grant:
  - Only one source requests: grant it.
  - Both request: grant the source not in rr_last.
  - rr_last updates to the granted source only on a grant.
- FIFO update per source:
  - pop = granted && count_X != 0.
  - push = X_fi && !(granted && count_X == 0).
  - count_X += push − pop.
  - Push and pop in the same cycle are legal, including at count == DEPTH.
- Full/overflow:
  - X_full = (count_X == DEPTH), decoded from registered count.
  - A push while count == DEPTH and not popping: entry dropped, overflow_err set, held until reset.
- Output register:
  - cdb_fi <= req_ALU || req_LSB.
  - When a grant occurs: cdb_value, cdb_rob_id, cdb_src <= the granted candidate.
  - When there is no grant: cdb_fi <= 0 and the data fields hold their previous values.
- FIFO order is preserved per source. There is no ordering between sources.

## Timing
- Reset, sampled on clk_in rising edge with rst_in = 0:
  - cdb_fi = 0, cdb_value = 0, cdb_rob_id = 0, cdb_src = 0.
  - Counts and pointers = 0, so alu_full = lsb_full = 0.
  - overflow_err = 0.
  - rr_last = LSB, so the ALU wins the first tie.
- Reset takes priority over rob_clear and rdy_in.
- rob_clear with rdy_in = 1 at edge N:
  - Both FIFOs are emptied, cdb_fi = 0 at N+1, rr_last = LSB.
  - Inputs arriving in cycle N are discarded.
  - overflow_err is unaffected.
- rdy_in = 0: no state changes; outputs hold their values, including cdb_fi.
- Latency: a result arriving with an empty FIFO and winning the grant appears on the CDB at the next edge (1 cycle).
  - Each lost arbitration adds 1 cycle.
  - Worst case for a head entry is 2 cycles.
- Throughput: exactly 1 broadcast per cycle while any request is pending.
- Simultaneous arrival with both FIFOs empty: one result is bypassed and the other is pushed; the pushed one broadcasts next cycle.
- Mid-operation reset or clear: no partial broadcast; the next cycle is idle.

## Test plan
- Reset with rst_in = 0 for 2 cycles, inputs idle:
  - cdb_fi = 0, alu_full = 0, lsb_full = 0, overflow_err = 0.
- Single ALU result (alu_fi = 1, value 0x12345678, rob_id 3), LSB idle:
  - Next cycle cdb_fi = 1, cdb_value = 0x12345678, cdb_rob_id = 3, cdb_src = 0.
  - Following cycle cdb_fi = 0.
- Simultaneous ALU (id 1) and LSB (id 2) results each cycle for 4 cycles, DEPTH = 2:
  - CDB ids alternate 1, 2, 1, 2… with the ALU first.
  - alu_full/lsb_full assert once counts reach 2.
  - No overflow when producers respect full.
- LSB burst of 3 (ids 4, 5, 6) while ALU idle:
  - CDB ids 4, 5, 6 on consecutive cycles; FIFO order preserved.
- Two entries queued per source, then rob_clear:
  - Next cycle cdb_fi = 0, both full = 0.
  - A subsequent ALU id 7 broadcasts 1 cycle later.
- With the LSB FIFO full, drive lsb_fi while the ALU wins the grant:
  - overflow_err = 1 and stays 1 through rob_clear.
- Hold rdy_in = 0 for 3 cycles with a queued entry:
  - CDB outputs and full flags are frozen.
  - Release: the entry broadcasts on the next edge.
